// File: rtl/pwm_yakalama_if.sv
// Wishbone slave bus bundle for the PWM capture peripheral.
// Signal names keep the slave-side _i/_o view so both ends read naturally.
interface pwm_yakalama_if;
  logic [5:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/pwm_yakalama.sv
// PWM input capture: measures period and high time of pwm_i in clk_i cycles,
// with timeout detection, one-shot mode and a level interrupt on a Wishbone slave.
module pwm_yakalama #(
  parameter int SAYAC_W    = 32,
  parameter int SENK_ASAMA = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pwm_yakalama_if.slave  wb,
  input  logic           pwm_i,
  output logic           irq_o
);

  typedef enum logic [1:0] {BOSTA, BEKLE, YUKSEK, DUSUK} durum_e;

  localparam logic [3:0] A_KONTROL = 4'h0;
  localparam logic [3:0] A_DURUM   = 4'h1;
  localparam logic [3:0] A_PERIYOT = 4'h2;
  localparam logic [3:0] A_YUKSEK  = 4'h3;
  localparam logic [3:0] A_SINIR   = 4'h4;
  localparam logic [3:0] A_ANLIK   = 4'h5;

  durum_e               st_q, st_d;
  logic [SAYAC_W-1:0]   cnt_q, cnt_d;
  logic [SAYAC_W-1:0]   ytmp_q, ytmp_d;
  logic [SAYAC_W-1:0]   per_q, per_d;
  logic [SAYAC_W-1:0]   yuk_q, yuk_d;
  logic [SAYAC_W-1:0]   sinir_q, sinir_d;
  logic                 en_q, en_d;
  logic                 irqen_q, irqen_d;
  logic                 tek_q, tek_d;
  logic                 gec_q, gec_d;
  logic                 zas_q, zas_d;
  logic                 ack_q;
  logic [31:0]          dat_q, dat_d;
  logic                 irq_q;
  logic [SENK_ASAMA-1:0] sync_q;
  logic                 prev_q;

  logic        s_pwm, rise, fall, tmo;
  logic        gec_set, zas_set, tek_clr;
  logic        fire, wr;
  logic [3:0]  idx;
  logic [31:0] bmask, rdata;
  logic        adr_unused;

  assign s_pwm = sync_q[SENK_ASAMA-1];
  assign rise  = s_pwm & ~prev_q;
  assign fall  = ~s_pwm & prev_q;
  assign tmo   = ((sinir_q != '0) && (cnt_q == sinir_q)) || (&cnt_q);

  assign fire = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr   = fire & wb.wb_we_i;
  assign idx  = wb.wb_adr_i[5:2];
  // byte offset within the word is not decoded
  assign adr_unused = ^wb.wb_adr_i[1:0];

  always_comb begin
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{wb.wb_sel_i[i]}};
  end

  // Measurement FSM
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ytmp_d  = ytmp_q;
    per_d   = per_q;
    yuk_d   = yuk_q;
    gec_set = 1'b0;
    zas_set = 1'b0;
    tek_clr = 1'b0;
    if (!en_q) begin
      st_d  = BOSTA;
      cnt_d = '0;
    end else begin
      case (st_q)
        BOSTA: begin
          cnt_d = '0;
          st_d  = BEKLE;
        end
        BEKLE: begin
          if (rise) begin
            cnt_d = SAYAC_W'(1);
            st_d  = YUKSEK;
          end
        end
        YUKSEK: begin
          if (tmo) begin
            zas_set = 1'b1;
            cnt_d   = '0;
            st_d    = BEKLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
              ytmp_d = cnt_q;
              st_d   = DUSUK;
            end
          end
        end
        DUSUK: begin
          if (tmo) begin
            zas_set = 1'b1;
            cnt_d   = '0;
            st_d    = BEKLE;
          end else if (rise) begin
            per_d   = cnt_q;
            yuk_d   = ytmp_q;
            gec_set = 1'b1;
            cnt_d   = SAYAC_W'(1);
            st_d    = YUKSEK;
            if (tek_q) begin
              tek_clr = 1'b1;
              st_d    = BOSTA;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: st_d = BOSTA;
      endcase
    end
  end

  // Register file: bus writes, W1C flags (hardware set wins over clear)
  always_comb begin
    en_d    = en_q;
    irqen_d = irqen_q;
    tek_d   = tek_q;
    sinir_d = sinir_q;
    gec_d   = gec_q;
    zas_d   = zas_q;
    if (tek_clr) en_d = 1'b0;
    if (wr) begin
      case (idx)
        A_KONTROL: if (wb.wb_sel_i[0]) {tek_d, irqen_d, en_d} = wb.wb_dat_i[2:0];
        A_DURUM: if (wb.wb_sel_i[0]) begin
          if (wb.wb_dat_i[0]) gec_d = 1'b0;
          if (wb.wb_dat_i[1]) zas_d = 1'b0;
        end
        A_SINIR: sinir_d = (sinir_q & ~bmask) | (wb.wb_dat_i & bmask);
        default: ;
      endcase
    end
    if (gec_set) gec_d = 1'b1;
    if (zas_set) zas_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      A_KONTROL: rdata = {29'b0, tek_q, irqen_q, en_q};
      A_DURUM:   rdata = {30'b0, zas_q, gec_q};
      A_PERIYOT: rdata = per_q;
      A_YUKSEK:  rdata = yuk_q;
      A_SINIR:   rdata = sinir_q;
      A_ANLIK:   rdata = {31'b0, s_pwm};
      default:   rdata = '0;
    endcase
    dat_d = fire ? rdata : dat_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= BOSTA;
      cnt_q   <= '0;
      ytmp_q  <= '0;
      per_q   <= '0;
      yuk_q   <= '0;
      sinir_q <= '0;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      tek_q   <= 1'b0;
      gec_q   <= 1'b0;
      zas_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ytmp_q  <= ytmp_d;
      per_q   <= per_d;
      yuk_q   <= yuk_d;
      sinir_q <= sinir_d;
      en_q    <= en_d;
      irqen_q <= irqen_d;
      tek_q   <= tek_d;
      gec_q   <= gec_d;
      zas_q   <= zas_d;
      ack_q   <= fire;
      dat_q   <= dat_d;
      irq_q   <= irqen_q & (gec_q | zas_q);
      sync_q  <= {sync_q[SENK_ASAMA-2:0], pwm_i};
      prev_q  <= s_pwm;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_pwm_yakalama.sv
// Directed bench for pwm_yakalama: register access, steady capture, W1C race,
// timeout, one-shot, abort/re-enable and asynchronous reset.
module tb_pwm_yakalama;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm = 1'b0;
  logic irq;

  pwm_yakalama_if bus();

  pwm_yakalama dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus),
    .pwm_i (pwm),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // PWM source: periodic when pwm_on, else a static level
  bit pwm_on  = 1'b0;
  bit pwm_lvl = 1'b0;
  int per = 100;
  int hi  = 30;
  int pc  = 0;
  always @(negedge clk) begin
    if (pwm_on) begin
      pwm = (pc < hi);
      pc  = (pc + 1 >= per) ? 0 : pc + 1;
    end else begin
      pwm = pwm_lvl;
      pc  = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Must be called right after a negedge; returns right after the next negedge.
  task automatic bus_cyc(input logic we, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    bit got = 1'b0;
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_sel_i = s;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) got = 1'b1;
    end
    q = bus.wb_dat_o;
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    chk("ack", {31'b0, got}, 32'd1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    @(negedge clk);
    bus_cyc(1'b1, a, d, s, q);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] q);
    @(negedge clk);
    bus_cyc(1'b0, a, 32'h0, 4'h0, q);
  endtask

  logic [31:0] q;

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int a = 0; a < 6; a++) begin
      rd(6'(a * 4), q);
      chk($sformatf("rst_reg%0d", a * 4), q, 32'd0);
    end

    // register access
    wr(6'h00, 32'h7, 4'b0010);
    rd(6'h00, q); chk("kontrol_sel_off", q, 32'h0);
    wr(6'h00, 32'h7, 4'b0001);
    rd(6'h00, q); chk("kontrol_rw", q, 32'h7);
    wr(6'h08, 32'hDEAD_BEEF, 4'hF);
    rd(6'h08, q); chk("periyot_ro", q, 32'h0);
    rd(6'h3C, q); chk("unmapped", q, 32'h0);
    wr(6'h10, 32'h1234_5678, 4'b0101);
    rd(6'h10, q); chk("sinir_lanes", q, 32'h0034_0078);
    wr(6'h10, 32'h0, 4'hF);
    wr(6'h00, 32'h0, 4'h1);

    // steady PWM 100/30
    per = 100; hi = 30; pwm_on = 1'b1;
    wr(6'h00, 32'h1, 4'h1);
    repeat (300) @(posedge clk);
    rd(6'h08, q); chk("steady_per", q, 32'd100);
    rd(6'h0C, q); chk("steady_hi", q, 32'd30);
    rd(6'h04, q); chk("steady_durum", q, 32'h1);
    chk("irq_masked", {31'b0, irq}, 32'd0);
    wr(6'h00, 32'h3, 4'h1);
    repeat (2) @(posedge clk);
    #1 chk("irq_on", {31'b0, irq}, 32'd1);

    // W1C lands on the exact completion cycle: set must win
    @(posedge pwm);
    @(negedge clk);
    @(negedge clk);
    bus_cyc(1'b1, 6'h04, 32'h1, 4'h1, q);
    rd(6'h04, q); chk("w1c_race", q, 32'h1);
    wr(6'h04, 32'h1, 4'h1);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    chk("irq_drop", {31'b0, irq}, 32'd0);
    rd(6'h04, q); chk("w1c_clear", q, 32'h0);

    // timeout at cnt == 50 with pwm stuck high
    wr(6'h00, 32'h0, 4'h1);
    pwm_on = 1'b0; pwm_lvl = 1'b0;
    wr(6'h10, 32'd50, 4'hF);
    wr(6'h04, 32'h3, 4'h1);
    wr(6'h00, 32'h3, 4'h1);
    repeat (5) @(posedge clk);
    #1 chk("irq_idle", {31'b0, irq}, 32'd0);
    @(posedge clk); #2 pwm_lvl = 1'b1;
    @(negedge clk);
    repeat (53) @(posedge clk);
    #1 chk("tmo_early", {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1 chk("tmo_irq", {31'b0, irq}, 32'd1);
    rd(6'h04, q); chk("tmo_durum", q, 32'h2);
    rd(6'h08, q); chk("tmo_per_keep", q, 32'd100);
    rd(6'h0C, q); chk("tmo_hi_keep", q, 32'd30);
    pwm_lvl = 1'b0;
    repeat (10) @(posedge clk);
    per = 40; hi = 10; pwm_on = 1'b1;
    repeat (150) @(posedge clk);
    rd(6'h08, q); chk("post_tmo_per", q, 32'd40);
    rd(6'h0C, q); chk("post_tmo_hi", q, 32'd10);

    // one-shot 20/5
    wr(6'h00, 32'h0, 4'h1);
    pwm_on = 1'b0;
    wr(6'h10, 32'h0, 4'hF);
    wr(6'h04, 32'h3, 4'h1);
    per = 20; hi = 5; pwm_on = 1'b1;
    wr(6'h00, 32'h5, 4'h1);
    repeat (100) @(posedge clk);
    rd(6'h08, q); chk("one_per", q, 32'd20);
    rd(6'h0C, q); chk("one_hi", q, 32'd5);
    rd(6'h00, q); chk("one_en_clr", q, 32'h4);
    rd(6'h04, q); chk("one_durum", q, 32'h1);
    per = 30; hi = 10;
    repeat (150) @(posedge clk);
    rd(6'h08, q); chk("one_per_hold", q, 32'd20);
    rd(6'h0C, q); chk("one_hi_hold", q, 32'd5);

    // abort mid-high, then re-enable mid-high
    wr(6'h04, 32'h3, 4'h1);
    per = 100; hi = 30;
    wr(6'h00, 32'h1, 4'h1);
    @(posedge pwm);
    repeat (10) @(posedge clk);
    wr(6'h00, 32'h0, 4'h1);
    repeat (250) @(posedge clk);
    rd(6'h08, q); chk("abort_per", q, 32'd20);
    rd(6'h04, q); chk("abort_durum", q, 32'h0);
    @(posedge pwm);
    repeat (10) @(posedge clk);
    wr(6'h00, 32'h3, 4'h1);
    @(posedge pwm);
    repeat (20) @(posedge clk);
    rd(6'h04, q); chk("reen_wait", q, 32'h0);
    repeat (100) @(posedge clk);
    rd(6'h04, q); chk("reen_durum", q, 32'h1);
    rd(6'h0C, q); chk("reen_hi", q, 32'd30);
    rd(6'h08, q); chk("reen_per", q, 32'd100);
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    chk("pre_rst_dat", bus.wb_dat_o, 32'd100);

    // asynchronous reset between clock edges
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_irq", {31'b0, irq}, 32'd0);
    chk("arst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
    chk("arst_dat", bus.wb_dat_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    rd(6'h08, q); chk("arst_per", q, 32'd0);
    rd(6'h00, q); chk("arst_kontrol", q, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
